// File: rtl/spi_mult_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_mult_pkg: shared widths, controller state encoding, timeout default
// Rev 1.0
// ------------------------------------------------------------------
package spi_mult_pkg;

  localparam int WORD_W              = 16;
  localparam int PROD_W              = 32;
  localparam int TIMEOUT_CYC_DEFAULT = 1_000_000;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ARM_A   = 4'd1,
    ST_WAIT_A  = 4'd2,
    ST_ARM_B   = 4'd3,
    ST_WAIT_B  = 4'd4,
    ST_MUL     = 4'd5,
    ST_SEND_HI = 4'd6,
    ST_WAIT_HI = 4'd7,
    ST_SEND_LO = 4'd8,
    ST_WAIT_LO = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult16.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_mult16: unsigned 16x16 shift-add multiplier, 16 cycles start->valid
// Rev 1.0
// ------------------------------------------------------------------
module seq_mult16
  import spi_mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              valid,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] mcand;
  logic [WORD_W-1:0] mplier;
  logic [PROD_W-1:0] acc;
  logic [3:0]        iter;

  // The first iteration is folded into the load so the result settles one
  // cycle early and valid lands exactly 16 edges after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      iter   <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{(PROD_W-WORD_W){1'b0}}, a} : '0;
        mcand  <= {{(PROD_W-WORD_W-1){1'b0}}, a, 1'b0};
        mplier <= {1'b0, b[WORD_W-1:1]};
        iter   <= 4'd1;
        busy   <= 1'b1;
      end else if (busy) begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= {mcand[PROD_W-2:0], 1'b0};
        mplier <= {1'b0, mplier[WORD_W-1:1]};
        iter   <= iter + 4'd1;
        if (iter == 4'd15) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign p = acc;

endmodule
`default_nettype wire

// File: rtl/spi_mult_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_mult_ctrl: receives two SPI operands, multiplies, returns product hi/lo
// Rev 1.0
// ------------------------------------------------------------------
module spi_mult_ctrl
  import spi_mult_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WORD_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_done,
  output logic              rx_start,
  output logic              tx_start,
  output logic [WORD_W-1:0] tx_data,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              rx_valid_q, tx_done_q;
  logic              rx_edge, tx_edge;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_expired;
  logic [WORD_W-1:0] op_a;
  logic              mult_start, mult_busy, mult_valid, mul_done;
  logic [PROD_W-1:0] mult_p;
  logic              accept, abort, latch_a, load_prod, load_lo, finish;

  assign rx_edge      = rx_valid & ~rx_valid_q;
  assign tx_edge      = tx_done  & ~tx_done_q;
  assign wait_expired = (wait_cnt == WAIT_LIMIT);
  assign mul_done     = mult_valid & ~mult_busy;
  assign busy         = (state != ST_IDLE);

  // Operand B goes straight from the SPI word into the multiplier load.
  seq_mult16 u_mult (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (op_a),
    .b     (rx_data),
    .busy  (mult_busy),
    .valid (mult_valid),
    .p     (mult_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rx_start   = 1'b0;
    tx_start   = 1'b0;
    mult_start = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    latch_a    = 1'b0;
    load_prod  = 1'b0;
    load_lo    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: if (en) begin
        accept    = 1'b1;
        state_nxt = ST_ARM_A;
      end
      ST_ARM_A: begin
        rx_start  = 1'b1;
        state_nxt = ST_WAIT_A;
      end
      ST_WAIT_A: if (rx_edge) begin
        latch_a   = 1'b1;
        state_nxt = ST_ARM_B;
      end else if (wait_expired) begin
        abort     = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ARM_B: begin
        rx_start  = 1'b1;
        state_nxt = ST_WAIT_B;
      end
      ST_WAIT_B: if (rx_edge) begin
        mult_start = 1'b1;
        state_nxt  = ST_MUL;
      end else if (wait_expired) begin
        abort     = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_MUL: if (mul_done) begin
        load_prod = 1'b1;
        state_nxt = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        tx_start  = 1'b1;
        state_nxt = ST_WAIT_HI;
      end
      ST_WAIT_HI: if (tx_edge) begin
        load_lo   = 1'b1;
        state_nxt = ST_SEND_LO;
      end else if (wait_expired) begin
        abort     = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_SEND_LO: begin
        tx_start  = 1'b1;
        state_nxt = ST_WAIT_LO;
      end
      ST_WAIT_LO: if (tx_edge) begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end else if (wait_expired) begin
        abort     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Every state change restarts the wait counter, so each WAIT_* begins at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      tx_done_q  <= 1'b0;
      wait_cnt   <= '0;
      op_a       <= '0;
      product    <= '0;
      tx_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      tx_done_q  <= tx_done;
      done       <= finish;
      if (state_nxt != state)       wait_cnt <= '0;
      else if (!wait_expired)       wait_cnt <= wait_cnt + 1'b1;
      if (accept)     err <= 1'b0;
      else if (abort) err <= 1'b1;
      if (latch_a) op_a <= rx_data;
      if (load_prod) begin
        product <= mult_p;
        tx_data <= mult_p[PROD_W-1:WORD_W];
      end
      if (load_lo) tx_data <= product[WORD_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_mult_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_spi_mult_ctrl: SPI-side driver with a cycle-timeline model of the outputs
// Rev 1.0
// ------------------------------------------------------------------
module tb_spi_mult_ctrl;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset, en, rx_valid, tx_done;
  logic [15:0] rx_data, tx_data;
  logic        rx_start, tx_start, busy, done, err;
  logic [31:0] product;

  spi_mult_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_done  (tx_done),
    .rx_start (rx_start),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .product  (product),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #10 clk = ~clk;

  // Expected outputs for the current cycle, advanced by the driver from the
  // documented cycle timings of each transaction phase.
  logic        m_rx_start = 0, m_tx_start = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic [15:0] m_tx_data = 0;
  logic [31:0] m_product = 0;

  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, done_cnt = 0, last_ts_cyc = 0;
  logic        prev_rs = 0, prev_ts = 0, chk_en = 0;
  logic [15:0] seen_tx[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (chk_en) begin
    chk("outputs", 64'({rx_start, tx_start, busy, done, err, tx_data, product}),
        64'({m_rx_start, m_tx_start, m_busy, m_done, m_err, m_tx_data, m_product}));
    if (rx_start) chk("rx_start_width", 64'(prev_rs), 64'(0));
    if (tx_start) chk("tx_start_width", 64'(prev_ts), 64'(0));
    if (tx_start && !prev_ts) begin
      seen_tx.push_back(tx_data);
      last_ts_cyc = cyc;
    end
    if (done) done_cnt++;
    prev_rs = rx_start;
    prev_ts = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_rx_start = 0;
    m_tx_start = 0;
    m_done     = 0;
  endtask

  // Quiet cycles with optional irrelevant events; the last cycle is always
  // low so a following real event is a genuine rising edge.
  task automatic idle_wait(input int d, input bit sp_rx, input bit sp_tx, input bit sp_en);
    for (int i = 0; i < d; i++) begin
      bit last;
      last     = (i == d - 1);
      rx_valid = sp_rx && !last && ($urandom_range(2, 0) == 0);
      tx_done  = sp_tx && !last && ($urandom_range(2, 0) == 0);
      en       = sp_en && !last && ($urandom_range(2, 0) == 0);
      rx_data  = 16'($urandom);
      tick();
    end
    rx_valid = 0;
    tx_done  = 0;
    en       = 0;
  endtask

  task automatic timeout_wait();
    repeat (TO - 1) tick();
    tick();
    m_busy = 0;
    m_err  = 1;
  endtask

  // abort_at: 0..3 withhold the A/B/HI/LO handshake, 4 reset mid-multiply, else full run
  task automatic txn(input logic [15:0] a, input logic [15:0] b, input int abort_at, input int hold);
    logic [31:0] p;
    int          b_cyc;
    p  = 32'(a) * 32'(b);
    en = 1;
    tick();
    en = 0;
    m_busy = 1; m_rx_start = 1; m_err = 0;
    tick();
    if (abort_at == 0) begin timeout_wait(); return; end
    idle_wait($urandom_range(6, 1), 0, 1, 1);
    rx_data = a; rx_valid = 1;
    tick();
    m_rx_start = 1;
    rx_valid = (hold > 0);
    rx_data  = 16'($urandom);
    tick();
    for (int i = 0; i < hold; i++) begin
      rx_data = 16'($urandom);
      tick();
    end
    rx_valid = 0;
    if (abort_at == 1) begin timeout_wait(); return; end
    idle_wait($urandom_range(6, 1), 0, 1, 1);
    rx_data = b; rx_valid = 1; b_cyc = cyc;
    tick();
    rx_valid = 0;
    if (abort_at == 4) begin
      repeat (7) tick();
      reset = 1;
      #1;
      m_busy = 0; m_err = 0; m_tx_data = 0; m_product = 0;
      chk("reset_mid_mul", 64'({rx_start, tx_start, busy, done, err, tx_data, product}), 64'(0));
      tick();
      tick();
      reset = 0;
      tick();
      return;
    end
    idle_wait(15, 1, 1, 1);
    tick();
    m_tx_start = 1; m_product = p; m_tx_data = p[31:16];
    tick();
    chk("b_edge_to_tx_start", 64'(last_ts_cyc - b_cyc), 64'(17));
    if (abort_at == 2) begin timeout_wait(); return; end
    idle_wait($urandom_range(6, 1), 1, 0, 1);
    tx_done = 1;
    tick();
    tx_done = 0;
    m_tx_start = 1; m_tx_data = p[15:0];
    tick();
    if (abort_at == 3) begin timeout_wait(); return; end
    idle_wait($urandom_range(6, 1), 1, 0, 1);
    tx_done = 1;
    tick();
    tx_done = 0;
    m_busy = 0; m_done = 1;
    tick();
  endtask

  task automatic directed(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] hi, input logic [15:0] lo);
    int n0, d0;
    n0 = seen_tx.size();
    d0 = done_cnt;
    txn(a, b, 5, 0);
    chk("tx_word_count", 64'(seen_tx.size() - n0), 64'(2));
    if (seen_tx.size() >= n0 + 2) begin
      chk("tx_hi_word", 64'(seen_tx[n0]), 64'(hi));
      chk("tx_lo_word", 64'(seen_tx[n0 + 1]), 64'(lo));
    end
    chk("product_word", 64'(product), 64'({hi, lo}));
    chk("done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("err_clear", 64'(err), 64'(0));
  endtask

  initial begin
    int n0, ab, hd;
    reset = 1; en = 0; rx_valid = 0; tx_done = 0; rx_data = 0;
    chk_en = 1;
    tick();
    tick();
    chk("reset_state", 64'({rx_start, tx_start, busy, done, err, tx_data, product}), 64'(0));
    reset = 0;
    tick();

    directed(16'h1234, 16'h5678, 16'h0626, 16'h0060);
    directed(16'h0000, 16'hABCD, 16'h0000, 16'h0000);
    directed(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);

    n0 = seen_tx.size();
    txn(16'h1111, 16'h2222, 1, 0);
    chk("timeout_err", 64'(err), 64'(1));
    chk("timeout_busy", 64'(busy), 64'(0));
    chk("timeout_product", 64'(product), 64'(32'hFFFE0001));
    chk("timeout_no_tx", 64'(seen_tx.size() - n0), 64'(0));
    idle_wait(3, 1, 1, 0);

    txn(16'h00C0, 16'h0101, 5, 3);
    chk("held_rx_valid_product", 64'(product), 64'(32'h0000C0C0));
    chk("err_cleared_by_en", 64'(err), 64'(0));

    txn(16'hBEEF, 16'h1234, 4, 0);
    directed(16'h0003, 16'h0007, 16'h0000, 16'h0015);

    for (int t = 0; t < 30; t++) begin
      ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(4, 0)) : 5;
      hd = ($urandom_range(2, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
      if (ab == 1) hd = 0;
      txn(16'($urandom), 16'($urandom), ab, hd);
      idle_wait($urandom_range(4, 0), 1, 1, 0);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
